// File: rtl/fwd_pkg.sv
// Shared types for the EX-stage forwarding control.
//   fwd_sel_t    : forward-select encoding consumed by the EX operand muxes
//   ex_entry_t   : shadow of the instruction sitting in EX
//   late_entry_t : shadow of the instructions in MEM and WB (producer info only)
package fwd_pkg;

    // Register-address width baked into the shadow entries; the top-level
    // REG_AW parameter must equal this value.
    localparam int FWD_REG_AW = 5;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,   // register-file read data
        FWD_MEM = 2'b01,   // MEM/WB writeback data
        FWD_ALU = 2'b10    // EX/MEM ALU result
    } fwd_sel_t;

    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] rs1;
        logic [FWD_REG_AW-1:0] rs2;
        logic                  uses_rs1;
        logic                  uses_rs2;
        logic [FWD_REG_AW-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } ex_entry_t;

    typedef struct packed {
        logic                  valid;
        logic [FWD_REG_AW-1:0] rd;
        logic                  reg_write;
    } late_entry_t;

    function automatic late_entry_t to_late(input ex_entry_t e);
        late_entry_t l;
        l.valid     = e.valid;
        l.rd        = e.rd;
        l.reg_write = e.reg_write;
        return l;
    endfunction

    // True when the entry will write 'src' (x0 is never a producer).
    function automatic logic produces(input late_entry_t e,
                                      input logic [FWD_REG_AW-1:0] src);
        return e.valid && e.reg_write && (e.rd == src) && (src != '0);
    endfunction

endpackage

// File: rtl/fwd_operand_sel.sv
// Forward select for one EX operand.
//   ex_valid : EX holds a real instruction
//   src      : source register of this operand
//   uses     : instruction actually reads this operand
//   mem_q    : shadow of MEM stage (youngest producer)
//   wb_q     : shadow of WB stage
//   sel      : FWD_ALU / FWD_MEM / FWD_REG
import fwd_pkg::*;

module fwd_operand_sel (
    input  logic                  ex_valid,
    input  logic [FWD_REG_AW-1:0] src,
    input  logic                  uses,
    input  late_entry_t           mem_q,
    input  late_entry_t           wb_q,
    output fwd_sel_t              sel
);

    always_comb begin
        sel = FWD_REG;
        if (ex_valid && uses && (src != '0)) begin
            // MEM first: when both stages write src, MEM is the newer value.
            if (produces(mem_q, src))
                sel = FWD_ALU;
            else if (produces(wb_q, src))
                sel = FWD_MEM;
        end
    end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// Forwarding / load-use hazard control for the 5-stage RV32 pipeline.
// Shadows the EX, MEM and WB destination info, drives the EX operand
// forward selects from that registered state, and raises a one-cycle
// decode stall for load-use pairs.
//   clk, rst_n          : clock, async active-low reset
//   id_*                : decode-stage instruction fields
//   flush               : redirect; instruction entering EX is killed
//   fwd_a_sel/fwd_b_sel : EX operand selects (00 RF, 10 ALU, 01 WB)
//   stall               : hold PC and IF/ID
//   stall_count         : saturating count of stall cycles
import fwd_pkg::*;

module forward_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              flush,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              stall,
    output logic [CNT_W-1:0]  stall_count
);

    ex_entry_t   ex_q, ex_d;
    late_entry_t mem_q, wb_q;
    logic        mem_load;   // MEM entry is a load; only used by the check below
    logic        hazard;

    // ---------------- load-use detection ----------------
    always_comb begin
        hazard = 1'b0;
        if (id_valid && ex_q.valid && ex_q.mem_read && ex_q.reg_write &&
            (ex_q.rd != '0)) begin
            hazard = (id_uses_rs1 && (id_rs1 == ex_q.rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_q.rd));
        end
    end

    // A flushed instruction is dead, so it never needs to wait.
    assign stall = hazard & ~flush;

    // ---------------- EX entry capture ----------------
    always_comb begin
        ex_d = '0;
        if (id_valid && !stall && !flush) begin
            ex_d.valid     = 1'b1;
            ex_d.rs1       = id_rs1;
            ex_d.rs2       = id_rs2;
            ex_d.uses_rs1  = id_uses_rs1;
            ex_d.uses_rs2  = id_uses_rs2;
            ex_d.rd        = id_rd;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= '0;
            mem_q    <= '0;
            wb_q     <= '0;
            mem_load <= 1'b0;
        end else begin
            ex_q     <= ex_d;
            mem_q    <= to_late(ex_q);
            wb_q     <= mem_q;
            mem_load <= ex_q.valid & ex_q.mem_read;
        end
    end

    // ---------------- stall counter ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_count <= '0;
        else if (stall && (stall_count != {CNT_W{1'b1}}))
            stall_count <= stall_count + 1'b1;
    end

    // ---------------- operand selects ----------------
    logic [1:0][FWD_REG_AW-1:0] src;
    logic [1:0]                 uses;
    fwd_sel_t                   sel [2];

    assign src[0]  = ex_q.rs1;
    assign src[1]  = ex_q.rs2;
    assign uses[0] = ex_q.uses_rs1;
    assign uses[1] = ex_q.uses_rs2;

    for (genvar i = 0; i < 2; i++) begin : g_op
        fwd_operand_sel u_sel (
            .ex_valid (ex_q.valid),
            .src      (src[i]),
            .uses     (uses[i]),
            .mem_q    (mem_q),
            .wb_q     (wb_q),
            .sel      (sel[i])
        );
    end

    assign fwd_a_sel = sel[0];
    assign fwd_b_sel = sel[1];

    // A load still in MEM feeding the EX instruction means the stall failed:
    // its data is not available on the ALU bypass yet.
    logic load_escape;
    always_comb begin
        load_escape = 1'b0;
        if (ex_q.valid && mem_load && mem_q.valid && mem_q.reg_write &&
            (mem_q.rd != '0)) begin
            load_escape = (ex_q.uses_rs1 && (ex_q.rs1 == mem_q.rd)) ||
                          (ex_q.uses_rs2 && (ex_q.rs2 == mem_q.rd));
        end
    end

    a_no_load_escape: assert property (@(posedge clk) disable iff (!rst_n) !load_escape);

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
module tb_forward_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0;
    logic       id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic       flush = 1'b0;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall;
    logic [1:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    forward_hazard_ctrl #(.REG_AW(5), .CNT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .flush        (flush),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .stall        (stall),
        .stall_count  (stall_count)
    );

    always #5 clk = ~clk;

    // Place one instruction in decode (called right after a negedge).
    task automatic drive(input logic v, input logic [4:0] r1, input logic u1,
                         input logic [4:0] r2, input logic u2,
                         input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v; id_rs1 = r1; id_uses_rs1 = u1; id_rs2 = r2; id_uses_rs2 = u2;
        id_rd = rd; id_reg_write = rw; id_mem_read = mr;
    endtask

    task automatic nop();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); nop();
        end
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL reset_a: got %b want 00", fwd_a_sel); end
        n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL reset_b: got %b want 00", fwd_b_sel); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_cmp++; if (stall_count !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", stall_count); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_alu_b2b();
        @(negedge clk); drive(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);      // add x5,x1,x2
        @(negedge clk); drive(1, 5'd5, 1, 5'd7, 1, 5'd6, 1, 0);      // sub x6,x5,x7
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall: got %b want 0", stall); end
        @(negedge clk); nop();
        n_cmp++; if (fwd_a_sel !== 2'b10) begin n_bad++; $display("FAIL b2b_a: got %b want 10", fwd_a_sel); end
        n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL b2b_b: got %b want 00", fwd_b_sel); end
        drain();
    endtask

    task automatic test_dist2();
        @(negedge clk); drive(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);      // add x5
        @(negedge clk); nop();
        @(negedge clk); drive(1, 5'd7, 1, 5'd5, 1, 5'd8, 1, 0);      // or x8,x7,x5
        @(negedge clk); nop();
        n_cmp++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL dist2_a: got %b want 00", fwd_a_sel); end
        n_cmp++; if (fwd_b_sel !== 2'b01) begin n_bad++; $display("FAIL dist2_b: got %b want 01", fwd_b_sel); end
        drain();
    endtask

    task automatic test_double_producer();
        @(negedge clk); drive(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0);      // add x5
        @(negedge clk); drive(1, 5'd5, 1, 5'd0, 0, 5'd5, 1, 0);      // addi x5,x5,1
        @(negedge clk); drive(1, 5'd5, 1, 5'd5, 1, 5'd9, 1, 0);      // and x9,x5,x5
        n_cmp++; if (fwd_a_sel !== 2'b10) begin n_bad++; $display("FAIL dbl_addi_a: got %b want 10", fwd_a_sel); end
        @(negedge clk); nop();
        n_cmp++; if (fwd_a_sel !== 2'b10) begin n_bad++; $display("FAIL dbl_a: got %b want 10", fwd_a_sel); end
        n_cmp++; if (fwd_b_sel !== 2'b10) begin n_bad++; $display("FAIL dbl_b: got %b want 10", fwd_b_sel); end
        drain();
    endtask

    task automatic test_load_use();
        @(negedge clk); drive(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);      // lw x5,0(x2)
        @(negedge clk); drive(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);      // add x6,x5,x1
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_stall: got %b want 1", stall); end
        @(negedge clk);                                               // decode held
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_stall_once: got %b want 0", stall); end
        n_cmp++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL lu_bubble_a: got %b want 00", fwd_a_sel); end
        @(negedge clk); nop();
        n_cmp++; if (fwd_a_sel !== 2'b01) begin n_bad++; $display("FAIL lu_a: got %b want 01", fwd_a_sel); end
        n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL lu_b: got %b want 00", fwd_b_sel); end
        n_cmp++; if (stall_count !== 2'd1) begin n_bad++; $display("FAIL lu_count: got %0d want 1", stall_count); end
        drain();
    endtask

    task automatic test_x0_flush();
        @(negedge clk); drive(1, 5'd1, 1, 5'd2, 1, 5'd0, 1, 0);      // add x0
        @(negedge clk); drive(1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0);      // add x3,x0,x0
        @(negedge clk); nop();
        n_cmp++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL x0_a: got %b want 00", fwd_a_sel); end
        n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL x0_b: got %b want 00", fwd_b_sel); end
        drain();
        @(negedge clk); drive(1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1);      // lw x0
        @(negedge clk); drive(1, 5'd0, 1, 5'd0, 0, 5'd4, 1, 0);      // uses x0
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL x0_load_stall: got %b want 0", stall); end
        drain();
        @(negedge clk); drive(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);      // lw x5
        @(negedge clk); drive(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0); flush = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b want 0", stall); end
        @(negedge clk); flush = 1'b0; nop();
        n_cmp++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL flush_killed_a: got %b want 00", fwd_a_sel); end
        n_cmp++; if (stall_count !== 2'd1) begin n_bad++; $display("FAIL flush_count: got %0d want 1", stall_count); end
        drain();
    endtask

    task automatic test_saturation();
        logic [1:0] want;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk); drive(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);  // lw x5
            @(negedge clk); drive(1, 5'd1, 1, 5'd5, 1, 5'd6, 1, 0);  // add x6,x1,x5
            @(negedge clk);                                            // held one cycle
            @(negedge clk); nop();
            want = (k > 3) ? 2'd3 : 2'(k);
            n_cmp++; if (stall_count !== want) begin n_bad++; $display("FAIL sat_count_%0d: got %0d want %0d", k, stall_count, want); end
        end
        drain();
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk); drive(1, 5'd1, 1, 5'd3, 1, 5'd2, 1, 0);      // add x2
        @(negedge clk); drive(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1);      // lw x5,0(x2)
        @(negedge clk); drive(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0);      // add x6,x5,x1
        n_cmp++; if (fwd_a_sel !== 2'b10) begin n_bad++; $display("FAIL rst_pre_a: got %b want 10", fwd_a_sel); end
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL rst_pre_stall: got %b want 1", stall); end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_cmp++; if (fwd_a_sel !== 2'b00) begin n_bad++; $display("FAIL rst_a: got %b want 00", fwd_a_sel); end
        n_cmp++; if (fwd_b_sel !== 2'b00) begin n_bad++; $display("FAIL rst_b: got %b want 00", fwd_b_sel); end
        n_cmp++; if (stall_count !== 2'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", stall_count); end
        nop();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_alu_b2b();
        test_dist2();
        test_double_producer();
        test_load_use();
        test_x0_flush();
        test_saturation();
        test_reset_mid_stall();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
